// File: rtl/alu_issue_stage.sv
// Issue stage for a combinational MIPS ALU: decode, regfile read, operand drive, writeback.
// Optional retire counter output enabled by defining ALU_ISSUE_RETIRE_CNT_EN.
module alu_issue_stage #(
    parameter int unsigned ALU_LAT = 1,
    parameter logic [5:0]  BEQ_OP  = 6'b000100,
    parameter logic [5:0]  BNE_OP  = 6'b000101
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [5:0]  OPCODE,
    output logic [31:0] RS_VAL,
    output logic [31:0] RT_VAL,
    output logic [4:0]  SHAMT,
    output logic [5:0]  FUNC,
    output logic [15:0] RAW_VAL,
    input  logic [31:0] RESULT,
    input  logic        SIG_B,
    output logic        WB_VALID,
    output logic [4:0]  WB_ADDR,
    output logic [31:0] WB_DATA,
    output logic        BR_TAKEN,
    output logic [15:0] BR_OFFSET,
    input  logic        DBG_WE,
    input  logic [4:0]  DBG_ADDR,
    input  logic [31:0] DBG_WDATA,
    output logic [31:0] DBG_RDATA
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    ,
    output logic [31:0] RETIRE_CNT
`endif
);

    localparam logic [3:0] CntInit = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

    state_e      state_q;
    logic [31:0] instr_q;
    logic [31:0] rf_q [32];
    logic [4:0]  dest_q;
    logic        branch_q;
    logic [3:0]  cnt_q;

    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_rd;
    logic [31:0] rt_rd;
    logic [4:0]  dec_dest;
    logic        dec_branch;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // Register 0 is hardwired to zero on every read path.
    always_comb begin
        rs_addr   = instr_q[25:21];
        rt_addr   = instr_q[20:16];
        rs_rd     = (rs_addr == 5'd0) ? 32'd0 : rf_q[rs_addr];
        rt_rd     = (rt_addr == 5'd0) ? 32'd0 : rf_q[rt_addr];
        DBG_RDATA = (DBG_ADDR == 5'd0) ? 32'd0 : rf_q[DBG_ADDR];
    end

    always_comb begin
        dec_branch = (instr_q[31:26] == BEQ_OP) || (instr_q[31:26] == BNE_OP);
        if (instr_q[31:26] == 6'd0) begin
            dec_dest = instr_q[15:11];
        end else if (dec_branch) begin
            dec_dest = 5'd0;
        end else begin
            dec_dest = instr_q[20:16];
        end
    end

    assign INSTR_READY = (state_q == StIdle) && !RST;

    // Debug writes only land in IDLE and writeback only in WB, so they never collide.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (state_q == StIdle && DBG_WE) begin
            rf_we    = 1'b1;
            rf_waddr = DBG_ADDR;
            rf_wdata = DBG_WDATA;
        end else if (state_q == StWb && !branch_q) begin
            rf_we    = 1'b1;
            rf_waddr = dest_q;
            rf_wdata = WB_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            instr_q   <= 32'd0;
            dest_q    <= 5'd0;
            branch_q  <= 1'b0;
            cnt_q     <= 4'd0;
            OPCODE    <= 6'd0;
            RS_VAL    <= 32'd0;
            RT_VAL    <= 32'd0;
            SHAMT     <= 5'd0;
            FUNC      <= 6'd0;
            RAW_VAL   <= 16'd0;
            WB_VALID  <= 1'b0;
            WB_ADDR   <= 5'd0;
            WB_DATA   <= 32'd0;
            BR_TAKEN  <= 1'b0;
            BR_OFFSET <= 16'd0;
        end else begin
            WB_VALID <= 1'b0;
            BR_TAKEN <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (INSTR_VALID) begin
                        instr_q <= INSTR;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    OPCODE   <= instr_q[31:26];
                    RS_VAL   <= rs_rd;
                    RT_VAL   <= rt_rd;
                    SHAMT    <= instr_q[10:6];
                    FUNC     <= instr_q[5:0];
                    RAW_VAL  <= instr_q[15:0];
                    dest_q   <= dec_dest;
                    branch_q <= dec_branch;
                    cnt_q    <= CntInit;
                    state_q  <= StExec;
                end
                StExec: begin
                    if (cnt_q == 4'd0) begin
                        // WB outputs are loaded here so they are valid for the whole WB cycle.
                        WB_VALID <= 1'b1;
                        if (branch_q) begin
                            WB_ADDR   <= 5'd0;
                            WB_DATA   <= 32'd0;
                            BR_TAKEN  <= SIG_B;
                            BR_OFFSET <= RAW_VAL;
                        end else begin
                            WB_ADDR <= dest_q;
                            WB_DATA <= RESULT;
                        end
                        state_q <= StWb;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StWb: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_RETIRE_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            RETIRE_CNT <= 32'd0;
        end else if (state_q == StWb) begin
            RETIRE_CNT <= RETIRE_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: two instances (ALU_LAT=1 and 4) fed the same stream,
// directed vector table, multi-cycle corner sequences and randomized traffic vs a reference model.
module tb_alu_issue_stage;

    localparam int NDUT = 2;

    logic        clk;
    logic        RST;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        DBG_WE;
    logic [4:0]  DBG_ADDR;
    logic [31:0] DBG_WDATA;

    logic        ready [NDUT];
    logic [5:0]  opc   [NDUT];
    logic [31:0] rs_v  [NDUT];
    logic [31:0] rt_v  [NDUT];
    logic [4:0]  sh    [NDUT];
    logic [5:0]  fn    [NDUT];
    logic [15:0] raw   [NDUT];
    logic [31:0] res   [NDUT];
    logic        sigb  [NDUT];
    logic        wbv   [NDUT];
    logic [4:0]  wba   [NDUT];
    logic [31:0] wbd   [NDUT];
    logic        brt   [NDUT];
    logic [15:0] bro   [NDUT];
    logic [31:0] dbgr  [NDUT];
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    logic [31:0] retire [NDUT];
`endif

    int n_total = 0;
    int n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU used both as the DUT's environment and by the reference model.
    function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [15:0] imm,
                                          input logic [5:0] f, input logic [4:0] s);
        if (op == 6'd0) begin
            case (f)
                6'h20:   return a + b;
                6'h22:   return a - b;
                6'h24:   return a & b;
                6'h25:   return a | b;
                6'h00:   return b << s;
                default: return a ^ b;
            endcase
        end
        if (op == 6'h0D) return a | {16'h0, imm};
        return a + {{16{imm[15]}}, imm};
    endfunction

    function automatic logic sig_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 6'd4) return a == b;
        if (op == 6'd5) return a != b;
        return 1'b0;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_alu
        assign res[g]  = alu_f(opc[g], rs_v[g], rt_v[g], raw[g], fn[g], sh[g]);
        assign sigb[g] = sig_f(opc[g], rs_v[g], rt_v[g]);
    end

    alu_issue_stage #(.ALU_LAT(1)) u_dut_lat1 (
        .CLK(clk), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(ready[0]),
        .OPCODE(opc[0]), .RS_VAL(rs_v[0]), .RT_VAL(rt_v[0]), .SHAMT(sh[0]), .FUNC(fn[0]),
        .RAW_VAL(raw[0]), .RESULT(res[0]), .SIG_B(sigb[0]), .WB_VALID(wbv[0]), .WB_ADDR(wba[0]),
        .WB_DATA(wbd[0]), .BR_TAKEN(brt[0]), .BR_OFFSET(bro[0]), .DBG_WE(DBG_WE),
        .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA), .DBG_RDATA(dbgr[0])
`ifdef ALU_ISSUE_RETIRE_CNT_EN
        , .RETIRE_CNT(retire[0])
`endif
    );

    alu_issue_stage #(.ALU_LAT(4)) u_dut_lat4 (
        .CLK(clk), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(ready[1]),
        .OPCODE(opc[1]), .RS_VAL(rs_v[1]), .RT_VAL(rt_v[1]), .SHAMT(sh[1]), .FUNC(fn[1]),
        .RAW_VAL(raw[1]), .RESULT(res[1]), .SIG_B(sigb[1]), .WB_VALID(wbv[1]), .WB_ADDR(wba[1]),
        .WB_DATA(wbd[1]), .BR_TAKEN(brt[1]), .BR_OFFSET(bro[1]), .DBG_WE(DBG_WE),
        .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA), .DBG_RDATA(dbgr[1])
`ifdef ALU_ISSUE_RETIRE_CNT_EN
        , .RETIRE_CNT(retire[1])
`endif
    );

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
        else n_pass++;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    typedef struct {
        logic [4:0]  a1;
        logic [31:0] v1;
        logic [4:0]  a2;
        logic [31:0] v2;
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        taken;
        logic [15:0] off;
        logic [31:0] reg_after;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] m_rf [32];
    int          n_retire;

    task automatic reset_all();
        @(negedge clk);
        RST = 1'b1;
        INSTR_VALID = 1'b0;
        DBG_WE = 1'b0;
        repeat (2) @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        DBG_WE = 1'b1;
        DBG_ADDR = a;
        DBG_WDATA = d;
        @(negedge clk);
        DBG_WE = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [4:0] a, input logic [31:0] e);
        DBG_ADDR = a;
        #1;
        for (int d = 0; d < NDUT; d++) chk(n, dbgr[d], e);
    endtask

    // Issues one instruction to both DUTs (both idle) and checks timing and results of each.
    task automatic run_instr(input string n, input logic [31:0] ins,
                             input logic sim_dbg, input logic [4:0] sd_a, input logic [31:0] sd_d,
                             input logic exec_dbg, input logic [4:0] ed_a, input logic [31:0] ed_d,
                             input logic [31:0] e_rs, input logic [31:0] e_rt,
                             input logic [4:0] e_addr, input logic [31:0] e_data,
                             input logic e_taken, input logic [15:0] e_off,
                             input logic [31:0] e_reg);
        int seen [NDUT];
        int nhi  [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            seen[d] = 0;
            nhi[d]  = 0;
        end
        @(negedge clk);
        INSTR = ins;
        INSTR_VALID = 1'b1;
        if (sim_dbg) begin
            DBG_WE = 1'b1;
            DBG_ADDR = sd_a;
            DBG_WDATA = sd_d;
        end
        #1;
        for (int d = 0; d < NDUT; d++) chk({n, ":ready_pre"}, 32'(ready[d]), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                INSTR_VALID = 1'b0;
                DBG_WE = 1'b0;
                INSTR = $urandom;
            end
            if (exec_dbg && k == 2) begin
                DBG_WE = 1'b1;
                DBG_ADDR = ed_a;
                DBG_WDATA = ed_d;
            end
            if (exec_dbg && k == 3) DBG_WE = 1'b0;
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (wbv[d]) begin
                    nhi[d]++;
                    if (seen[d] == 0) seen[d] = k;
                end
                if (k <= 2 + lat_of(d)) chk({n, ":ready_busy"}, 32'(ready[d]), 32'd0);
                if (k == 2) begin
                    chk({n, ":opcode"}, 32'(opc[d]), 32'(ins[31:26]));
                    chk({n, ":rs_val"}, rs_v[d], e_rs);
                    chk({n, ":rt_val"}, rt_v[d], e_rt);
                    chk({n, ":shamt"}, 32'(sh[d]), 32'(ins[10:6]));
                    chk({n, ":func"}, 32'(fn[d]), 32'(ins[5:0]));
                    chk({n, ":raw_val"}, 32'(raw[d]), 32'(ins[15:0]));
                end
                if (k == 2 + lat_of(d)) begin
                    chk({n, ":wb_addr"}, 32'(wba[d]), 32'(e_addr));
                    chk({n, ":wb_data"}, wbd[d], e_data);
                    chk({n, ":br_taken"}, 32'(brt[d]), 32'(e_taken));
                    if (e_taken) chk({n, ":br_offset"}, 32'(bro[d]), 32'(e_off));
                    chk({n, ":rs_hold"}, rs_v[d], e_rs);
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            chk({n, ":wb_latency"}, 32'(seen[d]), 32'(2 + lat_of(d)));
            chk({n, ":wb_pulses"}, 32'(nhi[d]), 32'd1);
            chk({n, ":ready_post"}, 32'(ready[d]), 32'd1);
        end
        rd_chk({n, ":reg_after"}, e_addr, e_reg);
    endtask

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        logic [31:0] a, b, r;
        logic [4:0]  dest, sd_a, ed_a;
        logic [31:0] sd_d, ed_d;
        logic        br, sd, ed, tk;

        RST = 1'b1;
        INSTR = 32'd0;
        INSTR_VALID = 1'b0;
        DBG_WE = 1'b0;
        DBG_ADDR = 5'd5;
        DBG_WDATA = 32'd0;

        tbl[0] = '{5'd1, 32'd15, 5'd2, 32'd12, 32'h00221820, 32'd15, 32'd12, 5'd3, 32'd27,
                   1'b0, 16'h0, 32'd27};
        tbl[1] = '{5'd5, 32'd7, 5'd6, 32'd7, 32'h10A60004, 32'd7, 32'd7, 5'd0, 32'd0,
                   1'b1, 16'h4, 32'd0};
        tbl[2] = '{5'd5, 32'd7, 5'd6, 32'd8, 32'h10A60004, 32'd7, 32'd8, 5'd0, 32'd0,
                   1'b0, 16'h0, 32'd0};
        tbl[3] = '{5'd1, 32'd15, 5'd2, 32'd12, 32'h00220020, 32'd15, 32'd12, 5'd0, 32'd27,
                   1'b0, 16'h0, 32'd0};
        tbl[4] = '{5'd5, 32'd7, 5'd6, 32'd8, 32'h14A60010, 32'd7, 32'd8, 5'd0, 32'd0,
                   1'b1, 16'h10, 32'd0};
        tbl[5] = '{5'd4, 32'h12340000, 5'd9, 32'd5, 32'h3489F0F0, 32'h12340000, 32'd5, 5'd9,
                   32'h1234F0F0, 1'b0, 16'h0, 32'h1234F0F0};
        tbl[6] = '{5'd11, 32'd100, 5'd12, 32'd30, 32'h016C5022, 32'd100, 32'd30, 5'd10, 32'd70,
                   1'b0, 16'h0, 32'd70};

        // Reset values, with RST still high.
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("rst:ready", 32'(ready[d]), 32'd0);
            chk("rst:wb_valid", 32'(wbv[d]), 32'd0);
            chk("rst:wb_addr", 32'(wba[d]), 32'd0);
            chk("rst:wb_data", wbd[d], 32'd0);
            chk("rst:br_taken", 32'(brt[d]), 32'd0);
            chk("rst:br_offset", 32'(bro[d]), 32'd0);
            chk("rst:opcode", 32'(opc[d]), 32'd0);
            chk("rst:rs_val", rs_v[d], 32'd0);
            chk("rst:rt_val", rt_v[d], 32'd0);
            chk("rst:raw_val", 32'(raw[d]), 32'd0);
            chk("rst:dbg_rdata", dbgr[d], 32'd0);
        end
        @(negedge clk);
        RST = 1'b0;

        for (int i = 0; i < 7; i++) begin
            dbg_write(tbl[i].a1, tbl[i].v1);
            dbg_write(tbl[i].a2, tbl[i].v2);
            run_instr($sformatf("vec%0d", i), tbl[i].ins, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                      tbl[i].rs, tbl[i].rt, tbl[i].addr, tbl[i].data, tbl[i].taken, tbl[i].off,
                      tbl[i].reg_after);
        end

        dbg_write(5'd0, 32'h0000FFFF);
        rd_chk("r0_dbg_write", 5'd0, 32'd0);

        // Debug write during EXEC is dropped; the same write in IDLE lands.
        run_instr("dbg_blocked", 32'h00221820, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000ABCD,
                  32'd15, 32'd12, 5'd3, 32'd27, 1'b0, 16'h0, 32'd27);
        rd_chk("dbg_blocked:r7", 5'd7, 32'd0);
        dbg_write(5'd7, 32'h0000ABCD);
        rd_chk("dbg_idle:r7", 5'd7, 32'h0000ABCD);

        // Back-to-back with INSTR_VALID held, on the ALU_LAT=1 instance; second accept
        // coincides with a debug write of one of its sources.
        reset_all();
        dbg_write(5'd1, 32'd23);
        dbg_write(5'd2, 32'd2);
        dbg_write(5'd5, 32'd35);
        @(negedge clk);
        INSTR = 32'h00221820;
        INSTR_VALID = 1'b1;
        #1;
        chk("b2b:ready0", 32'(ready[0]), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) INSTR = 32'h00252020;
            if (k == 4) begin
                DBG_WE = 1'b1;
                DBG_ADDR = 5'd1;
                DBG_WDATA = 32'd1;
            end
            if (k == 5) begin
                DBG_WE = 1'b0;
                INSTR_VALID = 1'b0;
            end
            #1;
            chk($sformatf("b2b:ready_k%0d", k), 32'(ready[0]), (k == 4) ? 32'd1 : 32'd0);
            if (k == 3 || k == 7) begin
                chk("b2b:wb_valid", 32'(wbv[0]), 32'd1);
                chk("b2b:wb_addr", 32'(wba[0]), (k == 3) ? 32'd3 : 32'd4);
                chk("b2b:wb_data", wbd[0], (k == 3) ? 32'd25 : 32'd36);
            end
        end
        @(negedge clk);
        DBG_ADDR = 5'd3;
        #1;
        chk("b2b:r3", dbgr[0], 32'd25);
        DBG_ADDR = 5'd4;
        #1;
        chk("b2b:r4", dbgr[0], 32'd36);

        // Reset during the second EXEC cycle of the ALU_LAT=4 instance.
        reset_all();
        dbg_write(5'd1, 32'd15);
        dbg_write(5'd2, 32'd12);
        @(negedge clk);
        INSTR = 32'h00221820;
        INSTR_VALID = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) INSTR_VALID = 1'b0;
            if (k == 3) RST = 1'b1;
            if (k == 4) RST = 1'b0;
            #1;
            chk($sformatf("rst_exec:no_wb_k%0d", k), 32'(wbv[1]), 32'd0);
            if (k == 3) chk("rst_exec:ready_in_rst", 32'(ready[1]), 32'd0);
            if (k >= 4) chk($sformatf("rst_exec:ready_k%0d", k), 32'(ready[1]), 32'd1);
        end
        DBG_ADDR = 5'd3;
        #1;
        chk("rst_exec:r3", dbgr[1], 32'd0);
        DBG_ADDR = 5'd1;
        #1;
        chk("rst_exec:r1_cleared", dbgr[1], 32'd0);

        // Randomized traffic against the reference model.
        reset_all();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        n_retire = 0;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                sd_a = 5'($urandom_range(0, 7));
                sd_d = $urandom;
                dbg_write(sd_a, sd_d);
                if (sd_a != 5'd0) m_rf[sd_a] = sd_d;
            end else begin
                case ($urandom_range(0, 5))
                    0:       op = 6'd0;
                    1:       op = 6'd4;
                    2:       op = 6'd5;
                    3:       op = 6'h0D;
                    4:       op = 6'h08;
                    default: op = 6'($urandom_range(6, 63));
                endcase
                ins = $urandom;
                ins[31:26] = op;
                ins[25:21] = 5'($urandom_range(0, 7));
                ins[20:16] = 5'($urandom_range(0, 7));
                ins[15:11] = 5'($urandom_range(0, 7));
                if (op == 6'd0) begin
                    case ($urandom_range(0, 4))
                        0:       ins[5:0] = 6'h20;
                        1:       ins[5:0] = 6'h22;
                        2:       ins[5:0] = 6'h24;
                        3:       ins[5:0] = 6'h00;
                        default: ins[5:0] = 6'h25;
                    endcase
                end
                sd   = ($urandom_range(0, 3) == 0);
                sd_a = 5'($urandom_range(0, 7));
                sd_d = $urandom;
                ed   = ($urandom_range(0, 3) == 0);
                ed_a = 5'($urandom_range(0, 7));
                ed_d = $urandom;
                if (sd && sd_a != 5'd0) m_rf[sd_a] = sd_d;
                a  = (ins[25:21] == 5'd0) ? 32'd0 : m_rf[ins[25:21]];
                b  = (ins[20:16] == 5'd0) ? 32'd0 : m_rf[ins[20:16]];
                br = (op == 6'd4) || (op == 6'd5);
                dest = (op == 6'd0) ? ins[15:11] : (br ? 5'd0 : ins[20:16]);
                r  = alu_f(op, a, b, ins[15:0], ins[5:0], ins[10:6]);
                tk = br && sig_f(op, a, b);
                if (!br && dest != 5'd0) m_rf[dest] = r;
                n_retire++;
                run_instr($sformatf("rnd%0d", it), ins, sd, sd_a, sd_d, ed, ed_a, ed_d, a, b,
                          dest, br ? 32'd0 : r, tk, ins[15:0],
                          (dest == 5'd0) ? 32'd0 : m_rf[dest]);
            end
        end
        for (int i = 0; i < 32; i++) begin
            rd_chk($sformatf("final_r%0d", i), 5'(i), (i == 0) ? 32'd0 : m_rf[i]);
        end
`ifdef ALU_ISSUE_RETIRE_CNT_EN
        for (int d = 0; d < NDUT; d++) chk("retire_cnt", retire[d], 32'(n_retire));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
